fetch_inst_align: RTL and testbench

Instruction alignment buffer that sits directly downstream of the hart-0 frontend response channel and upstream of decode. It accepts 32-bit fetch packets (two 16-bit parcels, per-parcel mask, fault flags) and emits one instruction per cycle. Each emitted instruction is either a 16-bit RVC or a 32-bit instruction, including 32-bit instructions that straddle two packets. Faults are attributed to the correct instruction, and the buffer supports a frontend-redirect kill.

---
 rtl/fetch_inst_align.sv | 160 ++++++++++++++++
 tb/tb_fetch_inst_align.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_inst_align.sv
// Instruction alignment buffer between the fetch response channel and decode.
// It splits 32-bit fetch packets into RVC / 32-bit instructions and joins instructions that straddle two packets.
module fetch_inst_align (
    input  logic        clock,
    input  logic        reset,
    input  logic        kill,
    input  logic        resp_valid,
    output logic        resp_ready,
    input  logic [31:0] resp_pc,
    input  logic [31:0] resp_data,
    input  logic [1:0]  resp_mask,
    input  logic        resp_xcpt_pf,
    input  logic        resp_xcpt_ae,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_bits,
    output logic [31:0] inst_pc,
    output logic        inst_rvc,
    output logic        inst_xcpt_pf,
    output logic        inst_xcpt_ae,
    output logic        inst_xcpt_hi
);

    logic        pkt_valid_q, pkt_valid_d;
    logic [31:0] pkt_data_q, pkt_data_d;
    logic [1:0]  pkt_mask_q, pkt_mask_d;
    logic [31:0] pkt_pc_q, pkt_pc_d;
    logic        pkt_pf_q, pkt_pf_d;
    logic        pkt_ae_q, pkt_ae_d;
    logic        cursor_q, cursor_d;
    logic        half_valid_q, half_valid_d;
    logic [15:0] half_data_q, half_data_d;
    logic [31:0] half_pc_q, half_pc_d;

    logic [31:0] base;
    logic [15:0] cur_parcel;
    logic        is_last, pkt_xcpt, half_join;
    logic        emit, retire_on_fire, to_half, fire, retire, accept;

    always_comb begin
        base       = {pkt_pc_q[31:2], 2'b00};
        cur_parcel = cursor_q ? pkt_data_q[31:16] : pkt_data_q[15:0];
        is_last    = cursor_q | ~pkt_mask_q[1];
        pkt_xcpt   = pkt_pf_q | pkt_ae_q;
        half_join  = half_valid_q && pkt_mask_q[0] && (base == half_pc_q + 32'd2);

        emit           = 1'b0;
        retire_on_fire = 1'b0;
        to_half        = 1'b0;
        inst_bits      = 32'd0;
        inst_pc        = 32'd0;
        inst_rvc       = 1'b0;
        inst_xcpt_pf   = 1'b0;
        inst_xcpt_ae   = 1'b0;
        inst_xcpt_hi   = 1'b0;

        if (pkt_valid_q) begin
            if (pkt_xcpt) begin
                // A faulting packet carries no usable data; it yields exactly one fault marker.
                emit           = 1'b1;
                retire_on_fire = 1'b1;
                inst_pc        = half_valid_q ? half_pc_q : pkt_pc_q;
                inst_xcpt_pf   = pkt_pf_q;
                inst_xcpt_ae   = pkt_ae_q;
                inst_xcpt_hi   = half_valid_q;
            end else if (half_join) begin
                emit           = 1'b1;
                retire_on_fire = ~pkt_mask_q[1];
                inst_bits      = {pkt_data_q[15:0], half_data_q};
                inst_pc        = half_pc_q;
            end else if (cur_parcel[1:0] != 2'b11) begin
                emit           = 1'b1;
                retire_on_fire = is_last;
                inst_bits      = {16'd0, cur_parcel};
                inst_pc        = base + (cursor_q ? 32'd2 : 32'd0);
                inst_rvc       = 1'b1;
            end else if (!is_last) begin
                emit           = 1'b1;
                retire_on_fire = 1'b1;
                inst_bits      = pkt_data_q;
                inst_pc        = base;
            end else begin
                to_half = 1'b1;
            end
        end

        inst_valid = emit && !kill && !reset;
        fire       = inst_valid && inst_ready;
        retire     = pkt_valid_q && (to_half || (fire && retire_on_fire));
        resp_ready = !reset && !kill && (!pkt_valid_q || retire);
        accept     = resp_valid && resp_ready;
    end

    always_comb begin
        pkt_valid_d  = pkt_valid_q && !retire;
        pkt_data_d   = pkt_data_q;
        pkt_mask_d   = pkt_mask_q;
        pkt_pc_d     = pkt_pc_q;
        pkt_pf_d     = pkt_pf_q;
        pkt_ae_d     = pkt_ae_q;
        cursor_d     = cursor_q;
        half_valid_d = half_valid_q;
        half_data_d  = half_data_q;
        half_pc_d    = half_pc_q;

        if (fire && !retire_on_fire)
            cursor_d = 1'b1;
        if (fire && (pkt_xcpt || half_join))
            half_valid_d = 1'b0;
        // A non-contiguous half is dropped as soon as the next packet is seen.
        if (pkt_valid_q && !pkt_xcpt && half_valid_q && !half_join)
            half_valid_d = 1'b0;
        if (to_half) begin
            half_valid_d = 1'b1;
            half_data_d  = cur_parcel;
            half_pc_d    = base + (cursor_q ? 32'd2 : 32'd0);
        end
        if (accept) begin
            pkt_valid_d = (resp_mask != 2'b00);
            pkt_data_d  = resp_data;
            pkt_mask_d  = resp_mask;
            pkt_pc_d    = resp_pc;
            pkt_pf_d    = resp_xcpt_pf;
            pkt_ae_d    = resp_xcpt_ae;
            cursor_d    = ~resp_mask[0];
        end
        if (kill) begin
            pkt_valid_d  = 1'b0;
            half_valid_d = 1'b0;
            cursor_d     = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pkt_valid_q  <= 1'b0;
            pkt_data_q   <= 32'd0;
            pkt_mask_q   <= 2'b00;
            pkt_pc_q     <= 32'd0;
            pkt_pf_q     <= 1'b0;
            pkt_ae_q     <= 1'b0;
            cursor_q     <= 1'b0;
            half_valid_q <= 1'b0;
            half_data_q  <= 16'd0;
            half_pc_q    <= 32'd0;
        end else begin
            pkt_valid_q  <= pkt_valid_d;
            pkt_data_q   <= pkt_data_d;
            pkt_mask_q   <= pkt_mask_d;
            pkt_pc_q     <= pkt_pc_d;
            pkt_pf_q     <= pkt_pf_d;
            pkt_ae_q     <= pkt_ae_d;
            cursor_q     <= cursor_d;
            half_valid_q <= half_valid_d;
            half_data_q  <= half_data_d;
            half_pc_q    <= half_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_inst_align.sv
// Bench for fetch_inst_align: cycle-exact directed table, then random packets vs a parcel-walk reference model.
module tb_fetch_inst_align;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        kill = 1'b0;
    logic        resp_valid = 1'b0;
    logic        resp_ready;
    logic [31:0] resp_pc = '0;
    logic [31:0] resp_data = '0;
    logic [1:0]  resp_mask = '0;
    logic        resp_xcpt_pf = 1'b0;
    logic        resp_xcpt_ae = 1'b0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst_bits;
    logic [31:0] inst_pc;
    logic        inst_rvc;
    logic        inst_xcpt_pf;
    logic        inst_xcpt_ae;
    logic        inst_xcpt_hi;

    fetch_inst_align dut (
        .clock(clock), .reset(reset), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_pc(resp_pc),
        .resp_data(resp_data), .resp_mask(resp_mask),
        .resp_xcpt_pf(resp_xcpt_pf), .resp_xcpt_ae(resp_xcpt_ae),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_bits(inst_bits),
        .inst_pc(inst_pc), .inst_rvc(inst_rvc), .inst_xcpt_pf(inst_xcpt_pf),
        .inst_xcpt_ae(inst_xcpt_ae), .inst_xcpt_hi(inst_xcpt_hi)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        logic        rst, kl, rv;
        logic [31:0] pc, data;
        logic [1:0]  mask;
        logic        pf, ir;
        logic        rr, iv;
        logic [31:0] bits, ipc;
        logic        rvc, epf, hi;
    } vec_t;

    typedef struct {
        logic [31:0] pc, data;
        logic [1:0]  mask;
        logic        pf, ae;
    } pkt_t;

    typedef struct {
        logic [31:0] pc, bits;
        logic        rvc, pf, ae, hi;
    } exp_t;

    function automatic vec_t V(input logic kl, input logic rv, input logic [31:0] pc,
                               input logic [31:0] data, input logic [1:0] mask, input logic pf,
                               input logic ir, input logic rr, input logic iv,
                               input logic [31:0] bits, input logic [31:0] ipc,
                               input logic rvc, input logic epf, input logic hi);
        vec_t v;
        v.rst = 1'b0; v.kl = kl; v.rv = rv; v.pc = pc; v.data = data; v.mask = mask;
        v.pf = pf; v.ir = ir; v.rr = rr; v.iv = iv; v.bits = bits; v.ipc = ipc;
        v.rvc = rvc; v.epf = epf; v.hi = hi;
        return v;
    endfunction

    function automatic vec_t IDLE(input logic rr);
        return V(0, 0, 0, 0, 0, 0, 1, rr, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t OUT(input logic rr, input logic [31:0] bits, input logic [31:0] ipc,
                                 input logic rvc, input logic ir);
        return V(0, 0, 0, 0, 0, 0, ir, rr, 1, bits, ipc, rvc, 0, 0);
    endfunction

    function automatic vec_t PKT(input logic [31:0] pc, input logic [31:0] data,
                                 input logic [1:0] mask, input logic pf, input logic rr);
        return V(0, 1, pc, data, mask, pf, 1, rr, 0, 0, 0, 0, 0, 0);
    endfunction

    // Expand the packet list into the instruction stream by walking parcels in address order.
    function automatic void model(input pkt_t pk[$], output exp_t q[$]);
        logic        hv = 1'b0;
        logic [15:0] hbits = '0;
        logic [31:0] hpc = '0;
        q = {};
        foreach (pk[k]) begin
            logic [31:0] b, d;
            int i, last;
            exp_t e;
            if (pk[k].mask == 2'b00) continue;
            b = pk[k].pc & ~32'd3;
            d = pk[k].data;
            if (pk[k].pf || pk[k].ae) begin
                e.pc = hv ? hpc : pk[k].pc; e.bits = 0; e.rvc = 0;
                e.pf = pk[k].pf; e.ae = pk[k].ae; e.hi = hv;
                q.push_back(e); hv = 0;
                continue;
            end
            i = pk[k].mask[0] ? 0 : 1;
            last = pk[k].mask[1] ? 1 : 0;
            if (hv) begin
                if (pk[k].mask[0] && b == hpc + 32'd2) begin
                    e.pc = hpc; e.bits = {d[15:0], hbits}; e.rvc = 0; e.pf = 0; e.ae = 0; e.hi = 0;
                    q.push_back(e); i = 1;
                end
                hv = 0;
            end
            while (i <= last) begin
                logic [15:0] p;
                p = d[i*16 +: 16];
                e.pf = 0; e.ae = 0; e.hi = 0;
                if (p[1:0] != 2'b11) begin
                    e.pc = b + 32'(2 * i); e.bits = {16'd0, p}; e.rvc = 1;
                    q.push_back(e); i = i + 1;
                end else if (i < last) begin
                    e.pc = b; e.bits = d; e.rvc = 0;
                    q.push_back(e); i = i + 2;
                end else begin
                    hv = 1; hbits = p; hpc = b + 32'(2 * i); i = i + 1;
                end
            end
        end
    endfunction

    vec_t tbl[$];
    pkt_t pk[$];
    exp_t eq[$];

    initial begin
        vec_t r;
        r = IDLE(0); r.rst = 1'b1;
        tbl.push_back(r); tbl.push_back(r);
        // aligned 32-bit, then two RVC with a new packet taken on the last fire
        tbl.push_back(PKT(32'h80000000, 32'h00000013, 2'b11, 0, 1));
        tbl.push_back(OUT(1, 32'h13, 32'h80000000, 0, 1));
        tbl.push_back(IDLE(1));
        tbl.push_back(PKT(32'h100, 32'h00010001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        r = OUT(1, 32'h1, 32'h102, 1, 1); r.rv = 1; r.pc = 32'h500; r.data = 32'h13; r.mask = 2'b11;
        tbl.push_back(r);
        tbl.push_back(OUT(1, 32'h13, 32'h500, 0, 1));
        tbl.push_back(IDLE(1));
        // straddle
        tbl.push_back(PKT(32'h100, 32'h00130001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        tbl.push_back(PKT(32'h104, 32'h00010000, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h13, 32'h102, 0, 1));
        tbl.push_back(OUT(1, 32'h1, 32'h106, 1, 1));
        tbl.push_back(IDLE(1));
        // straddle fault
        tbl.push_back(PKT(32'h100, 32'h00130001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        tbl.push_back(PKT(32'h104, 32'h00010000, 2'b11, 1, 1));
        tbl.push_back(V(0, 0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 32'h102, 0, 1, 1));
        tbl.push_back(IDLE(1));
        // backpressure
        r = PKT(32'h100, 32'h00010001, 2'b11, 0, 1); r.ir = 0;
        tbl.push_back(r);
        for (int i = 0; i < 3; i++) tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 0));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        tbl.push_back(OUT(1, 32'h1, 32'h102, 1, 1));
        tbl.push_back(IDLE(1));
        // kill while a half is held; packet offered during kill is refused
        tbl.push_back(PKT(32'h100, 32'h00130001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        tbl.push_back(IDLE(1));
        r = PKT(32'h202, 32'h00010000, 2'b10, 0, 0); r.kl = 1;
        tbl.push_back(r);
        tbl.push_back(PKT(32'h202, 32'h00010000, 2'b10, 0, 1));
        tbl.push_back(OUT(1, 32'h1, 32'h202, 1, 1));
        tbl.push_back(IDLE(1));
        // non-contiguous packet discards the half
        tbl.push_back(PKT(32'h100, 32'h00130001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h100, 1, 1));
        tbl.push_back(PKT(32'h200, 32'h00010001, 2'b11, 0, 1));
        tbl.push_back(OUT(0, 32'h1, 32'h200, 1, 1));
        tbl.push_back(OUT(1, 32'h1, 32'h202, 1, 1));
        tbl.push_back(IDLE(1));
        // empty mask, kill during a fire, straddle from mask 10 into mask 01
        tbl.push_back(PKT(32'h300, 32'hffffffff, 2'b00, 0, 1));
        tbl.push_back(IDLE(1));
        tbl.push_back(PKT(32'h100, 32'h00010001, 2'b11, 0, 1));
        r = IDLE(0); r.kl = 1;
        tbl.push_back(r);
        tbl.push_back(IDLE(1));
        tbl.push_back(PKT(32'h402, 32'h00130000, 2'b10, 0, 1));
        tbl.push_back(PKT(32'h404, 32'h12340000, 2'b01, 0, 1));
        tbl.push_back(OUT(1, 32'h13, 32'h402, 0, 1));
        tbl.push_back(IDLE(1));

        foreach (tbl[i]) begin
            @(posedge clock); #1;
            reset = tbl[i].rst; kill = tbl[i].kl; resp_valid = tbl[i].rv;
            resp_pc = tbl[i].pc; resp_data = tbl[i].data; resp_mask = tbl[i].mask;
            resp_xcpt_pf = tbl[i].pf; resp_xcpt_ae = 1'b0; inst_ready = tbl[i].ir;
            @(negedge clock);
            n_vec++;
            if (resp_ready !== tbl[i].rr || inst_valid !== tbl[i].iv ||
                (tbl[i].iv && (inst_bits !== tbl[i].bits || inst_pc !== tbl[i].ipc ||
                 inst_rvc !== tbl[i].rvc || inst_xcpt_pf !== tbl[i].epf ||
                 inst_xcpt_ae !== 1'b0 || inst_xcpt_hi !== tbl[i].hi))) begin
                n_bad++;
                $display("FAIL vec%0d: got rr=%b iv=%b bits=%h pc=%h rvc=%b pf=%b ae=%b hi=%b; want rr=%b iv=%b bits=%h pc=%h rvc=%b pf=%b hi=%b",
                         i, resp_ready, inst_valid, inst_bits, inst_pc, inst_rvc, inst_xcpt_pf,
                         inst_xcpt_ae, inst_xcpt_hi, tbl[i].rr, tbl[i].iv, tbl[i].bits,
                         tbl[i].ipc, tbl[i].rvc, tbl[i].epf, tbl[i].hi);
            end
        end

        // random packet stream
        begin
            logic [31:0] base;
            base = 32'h1000;
            for (int n = 0; n < 300; n++) begin
                pkt_t p;
                logic [15:0] h0, h1;
                if ($urandom_range(0, 3) == 0) base = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
                else base = base + 4;
                h0 = 16'($urandom); h1 = 16'($urandom);
                if ($urandom_range(0, 1) == 0) h0[1:0] = 2'($urandom_range(0, 2));
                if ($urandom_range(0, 1) == 0) h1[1:0] = 2'($urandom_range(0, 2));
                p.data = {h1, h0};
                p.mask = ($urandom_range(0, 31) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                p.pc = (p.mask == 2'b10) ? base + 32'd2 : base;
                p.pf = ($urandom_range(0, 15) == 0);
                p.ae = ($urandom_range(0, 23) == 0);
                pk.push_back(p);
            end
        end
        model(pk, eq);

        @(posedge clock); #1;
        reset = 1'b1; kill = 1'b0; resp_valid = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
        begin
            int idx = 0;
            int tail = 0;
            int cyc = 0;
            logic stall = 1'b0;
            logic [31:0] sbits = '0, spc = '0;
            while (tail < 10) begin
                if (cyc > 20000) begin
                    n_bad++;
                    $display("FAIL timeout: %0d packets left, %0d insts pending, want 0", 300 - idx, eq.size());
                    break;
                end
                @(posedge clock); #1;
                resp_valid = (idx < 300) && ($urandom_range(0, 3) != 0);
                if (idx < 300) begin
                    resp_pc = pk[idx].pc; resp_data = pk[idx].data; resp_mask = pk[idx].mask;
                    resp_xcpt_pf = pk[idx].pf; resp_xcpt_ae = pk[idx].ae;
                end
                inst_ready = ($urandom_range(0, 3) != 0);
                @(negedge clock);
                cyc++;
                if (stall) begin
                    n_vec++;
                    if (inst_valid !== 1'b1 || inst_bits !== sbits || inst_pc !== spc) begin
                        n_bad++;
                        $display("FAIL hold: got iv=%b bits=%h pc=%h, want iv=1 bits=%h pc=%h",
                                 inst_valid, inst_bits, inst_pc, sbits, spc);
                    end
                end
                stall = inst_valid && !inst_ready;
                sbits = inst_bits; spc = inst_pc;
                if (inst_valid && inst_ready) begin
                    n_vec++;
                    if (eq.size() == 0) begin
                        n_bad++;
                        $display("FAIL extra: got inst pc=%h bits=%h, want none", inst_pc, inst_bits);
                    end else begin
                        exp_t e;
                        e = eq.pop_front();
                        if (inst_pc !== e.pc || inst_bits !== e.bits || inst_rvc !== e.rvc ||
                            inst_xcpt_pf !== e.pf || inst_xcpt_ae !== e.ae || inst_xcpt_hi !== e.hi) begin
                            n_bad++;
                            $display("FAIL rnd: got pc=%h bits=%h rvc=%b pf=%b ae=%b hi=%b; want pc=%h bits=%h rvc=%b pf=%b ae=%b hi=%b",
                                     inst_pc, inst_bits, inst_rvc, inst_xcpt_pf, inst_xcpt_ae,
                                     inst_xcpt_hi, e.pc, e.bits, e.rvc, e.pf, e.ae, e.hi);
                        end
                    end
                end
                if (resp_valid && resp_ready) idx++;
                if (idx == 300 && eq.size() == 0) tail++;
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
